// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter that holds a grant for a whole multi-cycle transaction.
// The grant is released on the owner's last pulse, on request drop, or at a hold-time limit.
module rr_hold_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  localparam int              HC_W       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LIMIT = HC_W'(MAX_HOLD);
  localparam logic [ID_W-1:0] LAST_IDX   = ID_W'(N - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [HC_W-1:0] hold_cnt;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic            owner_req;
  logic            owner_last;
  logic            hold_at_limit;
  logic            release_now;
  logic [ID_W-1:0] next_ptr;

  // Index of the requester sitting 'off' places above the pointer, wrapping at N.
  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return ID_W'(s);
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < N; i++) begin
      if (!pick_valid && req[rot_idx(ptr, i)]) begin
        pick_valid = 1'b1;
        pick_id    = rot_idx(ptr, i);
      end
    end
  end

  // While in GRANT, gnt_id names the owner, so the owner's inputs are a simple select.
  assign owner_req     = req[gnt_id];
  assign owner_last    = last[gnt_id];
  assign hold_at_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);
  assign release_now   = !owner_req || owner_last || hold_at_limit;
  assign next_ptr      = (gnt_id == LAST_IDX) ? '0 : gnt_id + ID_W'(1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (pick_valid) begin
            gnt      <= N'(1) << pick_id;
            gnt_id   <= pick_id;
            busy     <= 1'b1;
            hold_cnt <= HC_W'(1);
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            // Abandon and last both outrank the hold limit, so timeout fires only on a pure expiry.
            timeout  <= owner_req && !owner_last && hold_at_limit;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            ptr      <= next_ptr;
            hold_cnt <= '0;
            state    <= IDLE;
          end else begin
            timeout <= 1'b0;
            if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LIMIT)) begin
              hold_cnt <= hold_cnt + HC_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (bus or datapath port) between N requesters.
- Unlike a single-cycle grant arbiter, it holds a grant for a whole multi-cycle transaction. It releases on the requester's `last` pulse, when the request is dropped, or at a hold-time limit.
- Sits between requester front-ends and the shared resource's mux select.

Parameters:
- N, 8, number of requesters (2..16).
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 = unlimited.
- ID_W, $clog2(N), width of gnt_id.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  N  per-requester request level; held until served or abandoned.
- last  in  N  per-requester end-of-transaction pulse; only meaningful with the matching gnt bit.
- gnt  out  N  registered one-hot grant, or all zero.
- gnt_id  out  ID_W  binary index of the granted requester; 0 when idle.
- busy  out  1  high while in GRANT.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, rst=1): gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
- Two states: IDLE and GRANT.
- IDLE, arbitration:
  - If req≠0, pick the first set bit searching upward from ptr with wrap (ptr, ptr+1, … N-1, 0, … ptr-1).
  - Register gnt (one-hot), gnt_id, busy=1, hold_cnt=1, and go to GRANT.
  - Latency: req sampled in cycle t gives gnt visible in cycle t+1.
- GRANT: hold the same gnt while the owner k keeps req[k]=1. Each cycle, evaluate release conditions in this priority:
  - (a) req[k]=0: release silently (abandon).
  - (b) last[k]=1: normal release.
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD: release and pulse timeout=1 in the next cycle.
  - Otherwise increment hold_cnt, saturating at MAX_HOLD.
- On any release, in the next cycle:
  - gnt=0, gnt_id=0, busy=0, state=IDLE.
  - ptr becomes (k+1) mod N, so the last owner gets lowest priority.
  - There is always exactly one dead cycle between grants; no back-to-back grant overlap.
- Boundary rules:
  - last[j] for j≠k is ignored, and so is any last while IDLE.
  - A request for k arriving again right after release may win only after all other pending requesters with higher rotated priority.
  - Timeout with req[k] still high: k re-enters arbitration at lowest priority.
  - Simultaneous last[k] and hold_cnt==MAX_HOLD: treated as a normal release, with no timeout pulse.
  - req[k] falling in the same cycle as last[k]: treated as abandon; same effect, ptr still advances.
  - Wrap: k=N-1 gives ptr=0.
  - rst asserted mid-grant: gnt drops asynchronously; ptr returns to 0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt is never asserted to a requester whose req was 0 in the arbitration cycle.
  - Starvation bound: a continuously requesting input is granted within (N-1)·(MAX_HOLD+1)+1 cycles when MAX_HOLD≠0.

Test Plan:
- Reset then req=8'h01, last[0] pulsed on the 3rd grant cycle -> gnt=8'h01 from cycle 1 to 3, gnt=0 at cycle 4, ptr=1.
- req=8'hFF held, each owner pulses last after 2 cycles -> grant order 0,1,2,…,7,0, each with a 1-cycle gap; gnt_id follows 0..7.
- req=8'h81 with ptr=7 -> gnt=8'h80 first; after release, gnt=8'h01 (wrap check).
- MAX_HOLD=4, req[3] held with no last -> gnt=8'h08 for exactly 4 cycles, then timeout=1 for one cycle and gnt=0. With req[5] also pending, the next grant is 8'h20.
- Owner drops req mid-grant, and last on a non-owner bit -> release only on the owner's req drop, no timeout; the foreign last has no effect.
- Assert rst during GRANT with gnt=8'h10 -> gnt=0 immediately (asynchronously). After deassert with req=8'h11, the grant goes to bit 0 (ptr reset).
